fifo_capture_scheduler: RTL and testbench

//  Sequences one fifo instance (FIFO_SIZE x DATA_WIDTH, push/pop strobes, clear) for pixel capture.

---
 rtl/fifo_capture_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_fifo_capture_scheduler.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_capture_scheduler.sv
// Capture-side sequencer for one FIFO: fills it from the pixel stream, drains full bursts to a
// valid/ready sink and flushes the remainder at frame end. Optional drop counter: SCHED_DROP_COUNTER_EN.
`timescale 1ns/1ps

module fifo_capture_scheduler #(
  parameter int FIFO_SIZE   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   capture_en,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   pixel_valid,
  input  logic [DATA_WIDTH-1:0]  pixel_data,
  output logic                   fifo_enable,
  output logic                   fifo_clear,
  output logic                   fifo_push,
  output logic                   fifo_pop,
  output logic [DATA_WIDTH-1:0]  fifo_in_data,
  input  logic [DATA_WIDTH-1:0]  fifo_out_data,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   frame_done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    FILL,
    PUSH,
    PSETTLE,
    POP,
    PWAIT,
    OUT,
    DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] OccFull = COUNT_WIDTH'(FIFO_SIZE);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   occupancy_q, occupancy_d;
  logic                     endPending_q, endPending_d;

  logic                     fifoEnable_q, fifoEnable_d;
  logic                     fifoClear_q, fifoClear_d;
  logic                     fifoPush_q, fifoPush_d;
  logic                     fifoPop_q, fifoPop_d;
  logic [DATA_WIDTH-1:0]    fifoInData_q, fifoInData_d;
  logic                     outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0]    outData_q, outData_d;
  logic                     frameDone_q, frameDone_d;
  logic                     busy_q, busy_d;

  // frame_end is only remembered here; it is acted on from FILL so a burst in flight finishes first.
  always_comb begin
    state_d      = state_q;
    occupancy_d  = occupancy_q;
    endPending_d = endPending_q;

    if (state_q != IDLE && frame_end) begin
      endPending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (capture_en && frame_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        occupancy_d  = '0;
        endPending_d = frame_end;
        state_d      = FILL;
      end
      FILL: begin
        if (pixel_valid) begin
          state_d = PUSH;
        end else if (endPending_q) begin
          state_d = (occupancy_q != '0) ? POP : DONE;
        end
      end
      PUSH: begin
        if (occupancy_q != OccFull) begin
          occupancy_d = occupancy_q + 1'b1;
        end
        state_d = PSETTLE;
      end
      PSETTLE: begin
        state_d = (occupancy_q == OccFull) ? POP : FILL;
      end
      POP: begin
        if (occupancy_q != '0) begin
          occupancy_d = occupancy_q - 1'b1;
        end
        state_d = PWAIT;
      end
      PWAIT: begin
        state_d = OUT;
      end
      OUT: begin
        if (outValid_q && out_ready) begin
          if (occupancy_q != '0) begin
            state_d = POP;
          end else if (endPending_q) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        occupancy_d  = '0;
        endPending_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop aligned with its state.
  always_comb begin
    fifoClear_d  = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
    fifoEnable_d = !fifoClear_d;
    fifoPush_d   = (state_d == PUSH);
    fifoPop_d    = (state_d == POP);
    outValid_d   = (state_d == OUT);
    frameDone_d  = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    fifoInData_d = fifoInData_q;
    outData_d    = outData_q;
    if (state_q == FILL && pixel_valid) begin
      fifoInData_d = pixel_data;
    end
    if (state_q == PWAIT) begin
      outData_d = fifo_out_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      occupancy_q  <= '0;
      endPending_q <= 1'b0;
      fifoEnable_q <= 1'b0;
      fifoClear_q  <= 1'b1;
      fifoPush_q   <= 1'b0;
      fifoPop_q    <= 1'b0;
      fifoInData_q <= '0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      frameDone_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      occupancy_q  <= occupancy_d;
      endPending_q <= endPending_d;
      fifoEnable_q <= fifoEnable_d;
      fifoClear_q  <= fifoClear_d;
      fifoPush_q   <= fifoPush_d;
      fifoPop_q    <= fifoPop_d;
      fifoInData_q <= fifoInData_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      frameDone_q  <= frameDone_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SCHED_DROP_COUNTER_EN
  logic                   dropEvent;
  logic [COUNT_WIDTH-1:0] dropCount_q, dropCount_d;

  // A word arriving while the sequencer is busy outside FILL has nowhere to go.
  always_comb begin
    dropEvent   = pixel_valid && (state_q != IDLE) && (state_q != FILL);
    dropCount_d = dropCount_q;
    if (state_q == CLEAR) begin
      dropCount_d = '0;
    end else if (dropEvent && (dropCount_q != '1)) begin
      dropCount_d = dropCount_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dropCount_q <= '0;
    end else begin
      dropCount_q <= dropCount_d;
    end
  end

  assign drop_count = dropCount_q;
`else
  assign drop_count = '0;
`endif

  assign fifo_enable  = fifoEnable_q;
  assign fifo_clear   = fifoClear_q;
  assign fifo_push    = fifoPush_q;
  assign fifo_pop     = fifoPop_q;
  assign fifo_in_data = fifoInData_q;
  assign out_valid    = outValid_q;
  assign out_data     = outData_q;
  assign frame_done   = frameDone_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_capture_scheduler.sv
// Directed bench for fifo_capture_scheduler with a behavioural FIFO and sink monitor around it.
`timescale 1ns/1ps

module tb_fifo_capture_scheduler;

  localparam int FifoSize = 8;
  localparam int DW       = 32;
  localparam int CW       = 16;
`ifdef SCHED_DROP_COUNTER_EN
  localparam int ExpDrops = 10;
`else
  localparam int ExpDrops = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          capture_en;
  logic          frame_start;
  logic          frame_end;
  logic          pixel_valid;
  logic [DW-1:0] pixel_data;
  logic          fifo_enable;
  logic          fifo_clear;
  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_in_data;
  logic [DW-1:0] fifo_out_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          frame_done;
  logic          busy;
  logic [CW-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  int pushCount = 0;
  int popCount = 0;
  int doneCount = 0;
  int overlapCount = 0;
  int rxAtDone = 0;
  int pushAtFirstRx = 0;
  logic [DW-1:0] rxQ[$];

  always #5 clock = ~clock;

  fifo_capture_scheduler #(
    .FIFO_SIZE(FifoSize),
    .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .capture_en(capture_en),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .pixel_valid(pixel_valid),
    .pixel_data(pixel_data),
    .fifo_enable(fifo_enable),
    .fifo_clear(fifo_clear),
    .fifo_push(fifo_push),
    .fifo_pop(fifo_pop),
    .fifo_in_data(fifo_in_data),
    .fifo_out_data(fifo_out_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .frame_done(frame_done),
    .busy(busy),
    .drop_count(drop_count)
  );

  // Stand-in for the controlled FIFO: word presented on out_data the edge after a pop strobe.
  logic [DW-1:0] fifoMem[FifoSize];
  int wrPtr = 0;
  int rdPtr = 0;
  always @(posedge clock) begin
    if (fifo_clear) begin
      wrPtr <= 0;
      rdPtr <= 0;
    end else begin
      if (fifo_push) begin
        fifoMem[wrPtr % FifoSize] <= fifo_in_data;
        wrPtr <= wrPtr + 1;
      end
      if (fifo_pop) begin
        fifo_out_data <= fifoMem[rdPtr % FifoSize];
        rdPtr <= rdPtr + 1;
      end
    end
  end

  // Mid-cycle observer of strobes, sink handshakes and frame_done pulses.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (fifo_push) pushCount++;
        if (fifo_pop) popCount++;
        if (fifo_push && fifo_pop) overlapCount++;
        if (out_valid && out_ready) begin
          if (rxQ.size() == 0) pushAtFirstRx = pushCount;
          rxQ.push_back(out_data);
        end
        if (frame_done) begin
          doneCount++;
          rxAtDone = rxQ.size();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic sendPixel(input logic [DW-1:0] data);
    pixel_data  = data;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic waitRx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rxQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitDone(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (doneCount > prev) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (fifo_clear !== 1'b1) begin failures++; $display("[TB] FAIL reset_clear got %b want 1", fifo_clear); end
    checks++; if (fifo_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable got %b want 0", fifo_enable); end
    checks++; if (fifo_push !== 1'b0 || fifo_pop !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes push %b pop %b want 0 0", fifo_push, fifo_pop); end
    checks++; if (fifo_in_data !== '0) begin failures++; $display("[TB] FAIL reset_in_data got %h want 0", fifo_in_data); end
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("[TB] FAIL reset_sink valid %b data %h want 0 0", out_valid, out_data); end
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_status done %b busy %b want 0 0", frame_done, busy); end
    checks++; if (drop_count !== '0) begin failures++; $display("[TB] FAIL reset_drops got %0d want 0", drop_count); end
    reset_n = 1'b1;
    tick();
    capture_en  = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || fifo_clear !== 1'b1) begin failures++; $display("[TB] FAIL capture_disabled busy %b clear %b want 0 1", busy, fifo_clear); end
    capture_en = 1'b1;
  endtask

  task automatic test_single_burst();
    int p0;
    int q0;
    bit ok;
    rxQ.delete();
    p0 = pushCount;
    q0 = popCount;
    startFrame();
    checks++; if (busy !== 1'b1 || fifo_enable !== 1'b1 || fifo_clear !== 1'b0) begin failures++; $display("[TB] FAIL fill_entry busy %b en %b clr %b want 1 1 0", busy, fifo_enable, fifo_clear); end
    pixel_data  = 32'hA100_0000;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    checks++; if (fifo_push !== 1'b1 || fifo_in_data !== 32'hA100_0000) begin failures++; $display("[TB] FAIL push_latency push %b data %h want 1 a1000000", fifo_push, fifo_in_data); end
    tick();
    checks++; if (fifo_push !== 1'b0) begin failures++; $display("[TB] FAIL push_width got %b want 0", fifo_push); end
    tick();
    tick();
    for (int i = 1; i < 7; i++) sendPixel(32'hA100_0000 + DW'(i));
    pixel_data  = 32'hA100_0007;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    checks++; if (fifo_pop !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL burst_pop pop %b valid %b want 1 0", fifo_pop, out_valid); end
    tick();
    checks++; if (fifo_pop !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL burst_pwait pop %b valid %b want 0 0", fifo_pop, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA100_0000) begin failures++; $display("[TB] FAIL first_word valid %b data %h want 1 a1000000", out_valid, out_data); end
    waitRx(8, 100, ok);
    tick();
    tick();
    checks++; if (!ok || rxQ.size() != 8) begin failures++; $display("[TB] FAIL burst_count got %0d want 8", rxQ.size()); end
    for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
      checks++; if (rxQ[i] !== 32'hA100_0000 + DW'(i)) begin failures++; $display("[TB] FAIL burst_word%0d got %h want %h", i, rxQ[i], 32'hA100_0000 + DW'(i)); end
    end
    checks++; if (pushAtFirstRx != p0 + 8) begin failures++; $display("[TB] FAIL push_before_sink got %0d want %0d", pushAtFirstRx - p0, 8); end
    checks++; if (popCount - q0 != 8) begin failures++; $display("[TB] FAIL burst_pops got %0d want 8", popCount - q0); end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || fifo_pop !== 1'b0) begin failures++; $display("[TB] FAIL refill busy %b valid %b pop %b want 1 0 0", busy, out_valid, fifo_pop); end
  endtask

  task automatic test_empty_flush();
    int q0;
    int d0;
    q0 = popCount;
    d0 = doneCount;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL empty_early_done got %b want 0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1 || fifo_clear !== 1'b1) begin failures++; $display("[TB] FAIL empty_done done %b clr %b want 1 1", frame_done, fifo_clear); end
    tick();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL empty_idle done %b busy %b want 0 0", frame_done, busy); end
    checks++; if (popCount != q0 || doneCount != d0 + 1) begin failures++; $display("[TB] FAIL empty_counts pops %0d dones %0d want 0 1", popCount - q0, doneCount - d0); end
  endtask

  task automatic test_partial_flush();
    int q0;
    int d0;
    bit ok;
    rxQ.delete();
    q0 = popCount;
    d0 = doneCount;
    startFrame();
    for (int i = 0; i < 8; i++) sendPixel(32'hB200_0000 + DW'(i));
    waitRx(8, 100, ok);
    tick();
    for (int i = 8; i < 11; i++) sendPixel(32'hB200_0000 + DW'(i));
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    waitDone(d0, 200, ok);
    tick();
    tick();
    checks++; if (!ok || rxQ.size() != 11) begin failures++; $display("[TB] FAIL flush_count got %0d want 11", rxQ.size()); end
    for (int i = 0; i < 11 && i < rxQ.size(); i++) begin
      checks++; if (rxQ[i] !== 32'hB200_0000 + DW'(i)) begin failures++; $display("[TB] FAIL flush_word%0d got %h want %h", i, rxQ[i], 32'hB200_0000 + DW'(i)); end
    end
    checks++; if (popCount - q0 != 11) begin failures++; $display("[TB] FAIL flush_pops got %0d want 11", popCount - q0); end
    checks++; if (doneCount - d0 != 1 || rxAtDone != 11) begin failures++; $display("[TB] FAIL flush_done pulses %0d words_before %0d want 1 11", doneCount - d0, rxAtDone); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle busy %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int q0;
    int d0;
    int bad;
    bit ok;
    rxQ.delete();
    d0 = doneCount;
    startFrame();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sendPixel(32'hC300_0000 + DW'(i));
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hC300_0000) begin failures++; $display("[TB] FAIL stall_first valid %b data %h want 1 c3000000", out_valid, out_data); end
    q0 = popCount;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 32'hC300_0000 || fifo_pop !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stall_hold unstable_cycles %0d want 0", bad); end
    checks++; if (popCount != q0) begin failures++; $display("[TB] FAIL stall_pops got %0d want 0", popCount - q0); end
    out_ready = 1'b1;
    waitRx(8, 100, ok);
    tick();
    checks++; if (!ok || rxQ.size() != 8) begin failures++; $display("[TB] FAIL stall_count got %0d want 8", rxQ.size()); end
    for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
      checks++; if (rxQ[i] !== 32'hC300_0000 + DW'(i)) begin failures++; $display("[TB] FAIL stall_word%0d got %h want %h", i, rxQ[i], 32'hC300_0000 + DW'(i)); end
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    waitDone(d0, 50, ok);
    tick();
    checks++; if (!ok || busy !== 1'b0) begin failures++; $display("[TB] FAIL stall_end done %b busy %b want 1 0", ok, busy); end
  endtask

  task automatic test_drops();
    int p0;
    int d0;
    bit ok;
    rxQ.delete();
    d0 = doneCount;
    startFrame();
    p0 = pushCount;
    for (int k = 0; k < 16; k++) begin
      pixel_data  = 32'hD400_0000 + DW'(k);
      pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
    tick();
    tick();
    checks++; if (pushCount - p0 != 6) begin failures++; $display("[TB] FAIL drop_accepted got %0d want 6", pushCount - p0); end
    checks++; if (drop_count !== CW'(ExpDrops)) begin failures++; $display("[TB] FAIL drop_count got %0d want %0d", drop_count, ExpDrops); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    waitDone(d0, 100, ok);
    tick();
    checks++; if (!ok || rxQ.size() != 6) begin failures++; $display("[TB] FAIL drop_words got %0d want 6", rxQ.size()); end
    for (int i = 0; i < 6 && i < rxQ.size(); i++) begin
      checks++; if (rxQ[i] !== 32'hD400_0000 + DW'(3 * i)) begin failures++; $display("[TB] FAIL drop_word%0d got %h want %h", i, rxQ[i], 32'hD400_0000 + DW'(3 * i)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int q0;
    int d0;
    bit ok;
    rxQ.delete();
    startFrame();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sendPixel(32'hE500_0000 + DW'(i));
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_in_out valid %b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("[TB] FAIL midreset_sink valid %b data %h want 0 0", out_valid, out_data); end
    checks++; if (fifo_clear !== 1'b1 || fifo_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ctrl clr %b en %b busy %b want 1 0 0", fifo_clear, fifo_enable, busy); end
    checks++; if (fifo_push !== 1'b0 || fifo_pop !== 1'b0 || fifo_in_data !== '0 || drop_count !== '0) begin failures++; $display("[TB] FAIL midreset_fifo push %b pop %b in %h drops %0d want 0 0 0 0", fifo_push, fifo_pop, fifo_in_data, drop_count); end
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    rxQ.delete();
    q0 = popCount;
    d0 = doneCount;
    startFrame();
    sendPixel(32'hF600_0000);
    sendPixel(32'hF600_0001);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    waitDone(d0, 100, ok);
    tick();
    checks++; if (!ok || rxQ.size() != 2 || popCount - q0 != 2) begin failures++; $display("[TB] FAIL postreset_count words %0d pops %0d want 2 2", rxQ.size(), popCount - q0); end
    for (int i = 0; i < 2 && i < rxQ.size(); i++) begin
      checks++; if (rxQ[i] !== 32'hF600_0000 + DW'(i)) begin failures++; $display("[TB] FAIL postreset_word%0d got %h want %h", i, rxQ[i], 32'hF600_0000 + DW'(i)); end
    end
  endtask

  task automatic test_coincident_end();
    int q0;
    int d0;
    bit ok;
    rxQ.delete();
    q0 = popCount;
    d0 = doneCount;
    startFrame();
    pixel_data  = 32'hA700_0055;
    pixel_valid = 1'b1;
    frame_end   = 1'b1;
    tick();
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
    checks++; if (fifo_push !== 1'b1) begin failures++; $display("[TB] FAIL coincident_push got %b want 1", fifo_push); end
    waitDone(d0, 100, ok);
    tick();
    tick();
    checks++; if (!ok || rxQ.size() != 1) begin failures++; $display("[TB] FAIL coincident_words got %0d want 1", rxQ.size()); end
    checks++; if (rxQ.size() > 0 && rxQ[0] !== 32'hA700_0055) begin failures++; $display("[TB] FAIL coincident_data got %h want a7000055", rxQ[0]); end
    checks++; if (popCount - q0 != 1 || doneCount - d0 != 1) begin failures++; $display("[TB] FAIL coincident_counts pops %0d dones %0d want 1 1", popCount - q0, doneCount - d0); end
  endtask

  initial begin
    reset_n     = 1'b0;
    capture_en  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    out_ready   = 1'b1;
    test_reset();
    test_single_burst();
    test_empty_flush();
    test_partial_flush();
    test_backpressure();
    test_drops();
    test_reset_mid_burst();
    test_coincident_end();
    checks++; if (overlapCount != 0) begin failures++; $display("[TB] FAIL push_pop_overlap got %0d want 0", overlapCount); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
